access_req_master: RTL and testbench

ACCESS_REQ_MASTER -- requirements
Module: access_req_master

---
 rtl/access_req_master.sv | 99 +++++++++
 tb/tb_access_req_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_req_master.sv
// Command-driven requester for a protected register: captures a host command,
// issues one request strobe, then waits for a grant/deny response or a timeout.
module access_req_master #(
  parameter int DW      = 8,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [IDW-1:0] cmd_usr_id,
  input  logic [DW-1:0]  cmd_data,
  output logic           req_valid,
  output logic [IDW-1:0] req_usr_id,
  output logic [DW-1:0]  req_data,
  input  logic           rsp_valid,
  input  logic           rsp_grant,
  output logic           done,
  output logic [1:0]     status,
  output logic [7:0]     deny_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] ST_GRANT   = 2'b00;
  localparam logic [1:0] ST_DENY    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // The timer reads 0 in the first WAIT cycle, so expiry is its TIMEOUT-th
  // WAIT cycle; a response in that same cycle takes priority.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [1:0]     status_nxt;
  logic [IDW-1:0] cap_usr;
  logic [DW-1:0]  cap_data;
  logic [7:0]     timer;
  logic           finish;

  // Next-state and completion-status decode.
  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    case (state)
      IDLE: if (cmd_valid) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT: begin
        if (rsp_valid) begin
          state_nxt  = DONE;
          status_nxt = rsp_grant ? ST_GRANT : ST_DENY;
        end else if (timer == TMO_LAST) begin
          state_nxt  = DONE;
          status_nxt = ST_TIMEOUT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign finish = (state == WAIT) && (state_nxt == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command capture, WAIT timer, status and deny counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_usr  <= '0;
      cap_data <= '0;
      timer    <= '0;
      status   <= ST_GRANT;
      deny_cnt <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        cap_usr  <= cmd_usr_id;
        cap_data <= cmd_data;
      end
      if (state == REQ)       timer <= '0;
      else if (state == WAIT) timer <= timer + 8'd1;
      if (finish) begin
        status <= status_nxt;
        if (status_nxt != ST_GRANT && deny_cnt != '1) deny_cnt <= deny_cnt + 8'd1;
      end
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign req_valid  = (state == REQ);
  assign done       = (state == DONE);
  // Captured values are only exposed while the strobe is high.
  assign req_usr_id = req_valid ? cap_usr  : '0;
  assign req_data   = req_valid ? cap_data : '0;

endmodule

// File: tb/tb_access_req_master.sv
module tb_access_req_master;

  localparam int DW      = 8;
  localparam int IDW     = 3;
  localparam int TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_usr_id;
  logic [DW-1:0]  cmd_data;
  logic           req_valid;
  logic [IDW-1:0] req_usr_id;
  logic [DW-1:0]  req_data;
  logic           rsp_valid;
  logic           rsp_grant;
  logic           done;
  logic [1:0]     status;
  logic [7:0]     deny_cnt;

  typedef struct {
    logic [1:0] st;
    logic [7:0] cnt;
    int         off;
  } exp_t;

  exp_t                rsp_q[$];
  logic [IDW+DW-1:0]   req_q[$];
  int                  n_assert = 0;
  int                  n_fail   = 0;
  logic [7:0]          model_deny = 8'd0;

  access_req_master #(.DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_usr_id(cmd_usr_id), .cmd_data(cmd_data),
    .req_valid(req_valid), .req_usr_id(req_usr_id), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_grant(rsp_grant),
    .done(done), .status(status), .deny_cnt(deny_cnt)
  );

  always #5 clk = ~clk;

  // One command: r = WAIT cycle (1-based) in which the response is driven, 0 = none.
  task automatic do_cmd(input logic [IDW-1:0] u, input logic [DW-1:0] d, input int r, input logic g);
    exp_t e;
    logic [IDW+DW-1:0] rq;
    logic seen;
    if (r >= 1 && r <= TIMEOUT) begin
      e.st  = g ? 2'b00 : 2'b01;
      e.off = r + 1;
    end else begin
      e.st  = 2'b10;
      e.off = TIMEOUT + 1;
    end
    if (e.st != 2'b00 && model_deny != 8'd255) model_deny = model_deny + 8'd1;
    e.cnt = model_deny;
    rsp_q.push_back(e);
    req_q.push_back({u, d});

    n_assert++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_usr_id = u; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    rq = req_q.pop_front();
    n_assert++;
    if (req_valid !== 1'b1 || req_usr_id !== rq[IDW+DW-1:DW] || req_data !== rq[DW-1:0]) begin
      n_fail++;
      $display("FAIL req_strobe: got v=%b id=%h d=%h want v=1 id=%h d=%h",
               req_valid, req_usr_id, req_data, rq[IDW+DW-1:DW], rq[DW-1:0]);
    end
    seen = 1'b0;
    for (int o = 1; o <= TIMEOUT + 4 && !seen; o++) begin
      @(negedge clk);
      if (o == 1) begin
        n_assert++;
        if (req_valid !== 1'b0 || req_data !== '0 || req_usr_id !== '0 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL req_after_req: got v=%b id=%h d=%h rdy=%b want 0 0 0 0",
                   req_valid, req_usr_id, req_data, cmd_ready);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        e = rsp_q.pop_front();
        n_assert++;
        if (status !== e.st || deny_cnt !== e.cnt || o != e.off) begin
          n_fail++;
          $display("FAIL done_result: got st=%b cnt=%0d off=%0d want st=%b cnt=%0d off=%0d",
                   status, deny_cnt, o, e.st, e.cnt, e.off);
        end
        rsp_valid = 1'b0;
      end else begin
        rsp_valid = (o == r);
        rsp_grant = g;
      end
    end
    if (!seen) begin
      n_assert++; n_fail++;
      $display("FAIL done_timeout: got no done want done within %0d cycles", TIMEOUT + 4);
      void'(rsp_q.pop_front());
    end
    rsp_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_one_cycle: got done=%b rdy=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; cmd_usr_id = 3'h7; cmd_data = 8'hFF;
    rsp_valid = 1'b1; rsp_grant = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (cmd_ready !== 1'b1 || req_valid !== 1'b0 || req_usr_id !== '0 || req_data !== '0) begin
      n_fail++;
      $display("FAIL reset_req: got rdy=%b v=%b id=%h d=%h want 1 0 0 00", cmd_ready, req_valid, req_usr_id, req_data);
    end
    n_assert++;
    if (done !== 1'b0 || status !== 2'b00 || deny_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got done=%b st=%b cnt=%0d want 0 00 0", done, status, deny_cnt);
    end
    cmd_valid = 1'b0; rsp_valid = 1'b0;
    rst = 1'b0;
    model_deny = 8'd0;
  endtask

  task automatic test_grant;
    do_cmd(3'h4, 8'hA5, 1, 1'b1);
  endtask

  task automatic test_deny;
    do_cmd(3'h2, 8'h3C, 1, 1'b0);
    do_cmd(3'h5, 8'h81, 4, 1'b1);
  endtask

  task automatic test_timeout;
    do_cmd(3'h1, 8'h55, 0, 1'b1);
    do_cmd(3'h6, 8'hC3, TIMEOUT, 1'b1);
    do_cmd(3'h3, 8'h0F, TIMEOUT, 1'b0);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic want;
    cmd_valid = 1'b1; cmd_usr_id = 3'h7; cmd_data = 8'h96;
    rsp_valid = 1'b1; rsp_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.st = 2'b00; e.cnt = model_deny; e.off = 0;
      rsp_q.push_back(e);
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) begin cmd_valid = 1'b0; rsp_valid = 1'b0; end
      want = (i % 4 == 3);
      n_assert++;
      if (done !== want) begin
        n_fail++; $display("FAIL b2b_done_c%0d: got %b want %b", i, done, want);
      end
      if (i % 4 == 1) begin
        n_assert++;
        if (req_valid !== 1'b1 || req_data !== 8'h96 || req_usr_id !== 3'h7) begin
          n_fail++; $display("FAIL b2b_req_c%0d: got v=%b id=%h d=%h want 1 7 96", i, req_valid, req_usr_id, req_data);
        end
      end
      if (done === 1'b1 && rsp_q.size() > 0) begin
        e = rsp_q.pop_front();
        n_assert++;
        if (status !== e.st || deny_cnt !== e.cnt) begin
          n_fail++; $display("FAIL b2b_result: got st=%b cnt=%0d want st=%b cnt=%0d", status, deny_cnt, e.st, e.cnt);
        end
      end
    end
    n_assert++;
    if (rsp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d pending want 0", rsp_q.size());
      rsp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_idle;
    logic [1:0] st0;
    st0 = status;
    rsp_valid = 1'b1; rsp_grant = 1'b0;
    repeat (3) @(negedge clk);
    rsp_valid = 1'b0;
    n_assert++;
    if (status !== st0 || deny_cnt !== model_deny || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_rsp: got st=%b cnt=%0d done=%b rdy=%b want st=%b cnt=%0d 0 1",
               status, deny_cnt, done, cmd_ready, st0, model_deny);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 260; i++) do_cmd(3'(i), 8'(i), 1, 1'b0);
    n_assert++;
    if (deny_cnt !== 8'd255) begin
      n_fail++; $display("FAIL deny_saturate: got %0d want 255", deny_cnt);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [IDW+DW-1:0] rq;
    logic saw_done;
    req_q.push_back({3'h4, 8'h5A});
    cmd_valid = 1'b1; cmd_usr_id = 3'h4; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    rq = req_q.pop_front();
    n_assert++;
    if (req_valid !== 1'b1 || req_data !== rq[DW-1:0]) begin
      n_fail++; $display("FAIL rstmid_req: got v=%b d=%h want 1 %h", req_valid, req_data, rq[DW-1:0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; rsp_valid = 1'b1; rsp_grant = 1'b0;
    model_deny = 8'd0;
    saw_done = 1'b0;
    #1;
    n_assert++;
    if (cmd_ready !== 1'b1 || req_valid !== 1'b0 || req_data !== '0 || req_usr_id !== '0 ||
        done !== 1'b0 || status !== 2'b00 || deny_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_values: got rdy=%b v=%b id=%h d=%h done=%b st=%b cnt=%0d want 1 0 0 00 0 00 0",
               cmd_ready, req_valid, req_usr_id, req_data, done, status, deny_cnt);
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_assert++;
    if (saw_done) begin
      n_fail++; $display("FAIL rstmid_no_done: got done pulse want none");
    end
    rst = 1'b0; rsp_valid = 1'b0;
    do_cmd(3'h2, 8'h3C, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_grant();
    test_deny();
    test_timeout();
    test_back_to_back();
    test_ignore_idle();
    test_saturation();
    test_ignore_idle();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
